// File: rtl/lpc_synthesis.sv
// FLAC LPC synthesis datapath: rebuilds PCM samples from warmup samples,
// quantised coefficients, a shift and a residual stream using one
// multiply-accumulate per cycle.
//   x[n] = r[n] + ((sum_{j<order} c[j]*x[n-1-j]) >>> shift)
// Optional feature macro: LPC_SAT_EN (saturate instead of wrap, sticky oOverflow).
module lpc_synthesis #(
  parameter int unsigned MAX_ORDER = 12,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned COEF_W    = 15,
  parameter int unsigned RES_W     = 18,
  parameter int unsigned ACC_W     = 40
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic                       iStart,
  input  logic [3:0]                 iOrder,
  input  logic [4:0]                 iShift,
  input  logic                       iCoefWr,
  input  logic [3:0]                 iCoefIdx,
  input  logic signed [COEF_W-1:0]   iCoef,
  input  logic                       iValid,
  input  logic signed [RES_W-1:0]    iData,
  output logic                       oReady,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oValid,
  output logic                       oOverflow
);

  localparam int unsigned PROD_W = COEF_W + SAMPLE_W;

  // Warmup samples and order-0 samples are produced on the accept edge
  // itself, so they share DONE with predicted samples.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_MAC    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic                       ready_d, valid_d;
  logic                       accept_c, warm_c, fin_c;
  logic [3:0]                 order_q, order_in_c;
  logic [4:0]                 shift_q;
  logic [3:0]                 warm_q;
  logic [3:0]                 j_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [RES_W-1:0]    res_q;
  logic signed [SAMPLE_W-1:0] hist_q [MAX_ORDER];
  logic signed [COEF_W-1:0]   coef_q [MAX_ORDER];

  logic signed [PROD_W-1:0]   prod_c;
  logic signed [ACC_W-1:0]    acc_sum_c, fin_acc_c, y_c;
  logic signed [RES_W-1:0]    fin_res_c;
  logic signed [SAMPLE_W-1:0] sat_c;
  logic                       ovf_c;

  // Orders beyond the register depth clamp to the deepest predictor.
  assign order_in_c = (iOrder > 4'(MAX_ORDER)) ? 4'(MAX_ORDER) : iOrder;

  // One MAC term per cycle and the final reconstruction adder.
  assign prod_c    = PROD_W'(coef_q[j_q]) * PROD_W'(hist_q[j_q]);
  assign acc_sum_c = acc_q + ACC_W'(prod_c);
  assign fin_acc_c = (state_q == S_MAC) ? acc_sum_c : '0;
  assign fin_res_c = (state_q == S_MAC) ? res_q : iData;
  assign y_c       = ACC_W'(fin_res_c) + (fin_acc_c >>> shift_q);

`ifdef LPC_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  // Clamp out-of-range results to the sample rails.
  always_comb begin
    ovf_c = (y_c > SMAX) || (y_c < SMIN);
    sat_c = SAMPLE_W'(y_c);
    if (y_c > SMAX) sat_c = {1'b0, {(SAMPLE_W-1){1'b1}}};
    if (y_c < SMIN) sat_c = {1'b1, {(SAMPLE_W-1){1'b0}}};
  end
`else
  assign ovf_c = 1'b0;
  assign sat_c = SAMPLE_W'(y_c);
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    accept_c = 1'b0;
    warm_c   = 1'b0;
    fin_c    = 1'b0;
    if (iStart) begin
      state_d = S_ACCEPT;
    end else begin
      case (state_q)
        S_ACCEPT, S_DONE: begin
          if (iValid) begin
            accept_c = 1'b1;
            if (warm_q < order_q) begin
              warm_c  = 1'b1;
              state_d = S_DONE;
            end else if (order_q == 4'd0) begin
              fin_c   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_MAC;
            end
          end else begin
            state_d = S_ACCEPT;
          end
        end
        S_MAC: begin
          if (j_q == order_q - 4'd1) begin
            fin_c   = 1'b1;
            state_d = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
    ready_d = (state_d == S_ACCEPT) || (state_d == S_DONE);
    valid_d = warm_c || fin_c;
  end

  // State register and registered outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= S_IDLE;
      oReady    <= 1'b0;
      oValid    <= 1'b0;
      oSample   <= '0;
      oOverflow <= 1'b0;
    end else if (iEnable) begin
      state_q <= state_d;
      oReady  <= ready_d;
      oValid  <= valid_d;
      if (warm_c) oSample <= SAMPLE_W'(iData);
      else if (fin_c) oSample <= sat_c;
      if (iStart) oOverflow <= 1'b0;
      else if (fin_c && ovf_c) oOverflow <= 1'b1;
    end
  end

  // Subframe config, warmup count, MAC accumulator and sample history.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      order_q <= '0;
      shift_q <= '0;
      warm_q  <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      for (int k = 0; k < MAX_ORDER; k++) hist_q[k] <= '0;
    end else if (iEnable) begin
      if (iStart) begin
        order_q <= order_in_c;
        shift_q <= iShift;
        warm_q  <= '0;
        j_q     <= '0;
      end else begin
        if (state_q == S_DONE) begin
          for (int k = MAX_ORDER - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
          hist_q[0] <= oSample;
        end
        if (accept_c) begin
          res_q <= iData;
          acc_q <= '0;
          j_q   <= '0;
          if (warm_c) warm_q <= warm_q + 4'd1;
        end else if (state_q == S_MAC) begin
          acc_q <= acc_sum_c;
          j_q   <= fin_c ? 4'd0 : j_q + 4'd1;
        end
      end
    end
  end

  // Coefficient bank; frozen while a prediction is being accumulated.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int k = 0; k < MAX_ORDER; k++) coef_q[k] <= '0;
    end else if (iEnable) begin
      if (iCoefWr && (state_q != S_MAC) && (iCoefIdx < 4'(MAX_ORDER)))
        coef_q[iCoefIdx] <= iCoef;
    end
  end

endmodule

// File: tb/tb_lpc_synthesis.sv
// Randomised self-checking bench for lpc_synthesis against an arithmetic
// reference model (floor division, modular wrap, array history).
module tb_lpc_synthesis;

  logic               iClock;
  logic               iReset;
  logic               iEnable;
  logic               iStart;
  logic [3:0]         iOrder;
  logic [4:0]         iShift;
  logic               iCoefWr;
  logic [3:0]         iCoefIdx;
  logic signed [14:0] iCoef;
  logic               iValid;
  logic signed [17:0] iData;
  logic               oReady;
  logic signed [15:0] oSample;
  logic               oValid;
  logic               oOverflow;

  int checks = 0;
  int errors = 0;

  longint m_coef [12];
  longint m_hist [12];
  int     m_order, m_shift, m_warm;
  bit     m_ovf;

  lpc_synthesis dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
    .iOrder(iOrder), .iShift(iShift), .iCoefWr(iCoefWr), .iCoefIdx(iCoefIdx),
    .iCoef(iCoef), .iValid(iValid), .iData(iData), .oReady(oReady),
    .oSample(oSample), .oValid(oValid), .oOverflow(oOverflow)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrap16(input longint y);
    longint t;
    t = (y + 32768) % 65536;
    if (t < 0) t += 65536;
    return t - 32768;
  endfunction

  function automatic longint floor_div(input longint n, input int s);
    longint d;
    d = longint'(1) << s;
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic longint finish_y(input longint y);
`ifdef LPC_SAT_EN
    if (y > 32767) begin m_ovf = 1'b1; return 32767; end
    if (y < -32768) begin m_ovf = 1'b1; return -32768; end
`endif
    return wrap16(y);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 12; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
    m_order = 0; m_shift = 0; m_warm = 0; m_ovf = 1'b0;
  endtask

  task automatic wr_coef(input int idx, input longint val);
    iCoefWr = 1'b1; iCoefIdx = 4'(idx); iCoef = 15'(val);
    @(posedge iClock); #1;
    iCoefWr = 1'b0;
    if (idx < 12) m_coef[idx] = val;
  endtask

  task automatic start(input int order, input int shift);
    iStart = 1'b1; iOrder = 4'(order); iShift = 5'(shift);
    @(posedge iClock); #1;
    iStart = 1'b0;
    m_order = (order > 12) ? 12 : order;
    m_shift = shift; m_warm = 0; m_ovf = 1'b0;
    chk("start_ready", longint'(oReady), 1);
    chk("start_novalid", longint'(oValid), 0);
  endtask

  // Push one input, optionally stalling or attempting a coef write mid-MAC.
  task automatic send(input longint d, input int stall, input bit junk);
    longint exp_s, sum;
    int exp_lat, lat, n;
    if (m_warm < m_order) begin
      exp_s = wrap16(d); m_warm++; exp_lat = 1;
    end else if (m_order == 0) begin
      exp_s = finish_y(d); exp_lat = 1;
    end else begin
      sum = 0;
      for (int j = 0; j < m_order; j++) sum += m_coef[j] * m_hist[j];
      exp_s = finish_y(d + floor_div(sum, m_shift));
      exp_lat = m_order + 1;
    end
    n = 0;
    while (!oReady && n < 50) begin @(posedge iClock); #1; n++; end
    chk("ready", longint'(oReady), 1);
    iValid = 1'b1; iData = 18'(d);
    @(posedge iClock); #1;
    iValid = 1'b0;
    lat = 1;
    if (stall > 0 && exp_lat > 1) begin
      iEnable = 1'b0;
      repeat (stall) @(posedge iClock);
      #1;
      iEnable = 1'b1;
      lat += stall; exp_lat += stall;
    end
    if (junk && exp_lat > 1 && !oValid) begin
      iCoefWr = 1'b1; iCoefIdx = 4'd0; iCoef = 15'($urandom);
      @(posedge iClock); #1;
      iCoefWr = 1'b0;
      lat++;
    end
    while (!oValid && lat < 60) begin @(posedge iClock); #1; lat++; end
    chk("valid", longint'(oValid), 1);
    chk("sample", longint'(oSample), exp_s);
    chk("latency", longint'(lat), longint'(exp_lat));
    chk("overflow", longint'(oOverflow), longint'(m_ovf));
    for (int k = 11; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = exp_s;
  endtask

  initial begin
    int seen, o, sh, cnt, stl;
    logic signed [17:0] r18;
    longint d;
    iReset = 1'b0; iEnable = 1'b1; iStart = 1'b0; iOrder = '0; iShift = '0;
    iCoefWr = 1'b0; iCoefIdx = '0; iCoef = '0; iValid = 1'b0; iData = '0;
    model_reset();
    repeat (2) @(posedge iClock);
    #1;
    chk("rst_ready", longint'(oReady), 0);
    chk("rst_valid", longint'(oValid), 0);
    chk("rst_sample", longint'(oSample), 0);
    chk("rst_ovf", longint'(oOverflow), 0);
    iReset = 1'b1;
    @(posedge iClock); #1;
    chk("idle_ready", longint'(oReady), 0);

    // Order 2 ramp with an enable stall and an ignored mid-MAC coef write.
    wr_coef(0, 2); wr_coef(1, -1);
    start(2, 0);
    send(10, 0, 0); send(20, 0, 0); send(0, 0, 0); send(0, 3, 0); send(0, 0, 1);
    chk("t1_last", longint'(oSample), 50);

    // Order 1 with shift, then restart to exercise arithmetic floor.
    wr_coef(0, 3);
    start(1, 1);
    send(4, 0, 0); send(0, 0, 0); send(0, 0, 0);
    chk("t2_nine", longint'(oSample), 9);
    start(1, 1);
    send(-5, 0, 0); send(0, 0, 0);
    chk("t2_floor", longint'(oSample), -8);

    // Order 0 back-to-back, ready never drops.
    start(0, 0);
    send(7, 0, 0);
    chk("b2b_ready", longint'(oReady), 1);
    send(-3, 0, 0);
    chk("b2b_ready2", longint'(oReady), 1);

    // Result beyond sample range.
    wr_coef(0, 2);
    start(1, 0);
    send(20000, 0, 0); send(0, 0, 0);
`ifdef LPC_SAT_EN
    chk("t4_sat", longint'(oSample), 32767);
`else
    chk("t4_wrap", longint'(oSample), -25536);
`endif

    // Restart during MAC drops the pending sample.
    wr_coef(0, 2); wr_coef(1, -1);
    start(2, 0);
    send(1, 0, 0); send(2, 0, 0);
    iValid = 1'b1; iData = 18'sd0;
    @(posedge iClock); #1;
    iValid = 1'b0;
    iStart = 1'b1; iOrder = 4'd2; iShift = 5'd0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge iClock); #1;
      iStart = 1'b0;
      if (oValid) seen++;
    end
    m_order = 2; m_shift = 0; m_warm = 0; m_ovf = 1'b0;
    chk("abort_novalid", longint'(seen), 0);
    send(11, 0, 0);

    // Asynchronous reset in the middle of a MAC.
    start(2, 0);
    send(5, 0, 0); send(6, 0, 0);
    iValid = 1'b1; iData = 18'sd3;
    @(posedge iClock); #1;
    iValid = 1'b0;
    #2 iReset = 1'b0;
    #1;
    chk("arst_ready", longint'(oReady), 0);
    chk("arst_valid", longint'(oValid), 0);
    chk("arst_sample", longint'(oSample), 0);
    chk("arst_ovf", longint'(oOverflow), 0);
    repeat (2) @(posedge iClock);
    #3 iReset = 1'b1;
    @(posedge iClock); #1;
    model_reset();
    wr_coef(0, 2); wr_coef(1, -1);
    start(2, 0);
    send(10, 0, 0); send(20, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    chk("t6_last", longint'(oSample), 50);

    // Random subframes, including clamped orders.
    for (int s = 0; s < 25; s++) begin
      for (int k = 0; k < 12; k++)
        wr_coef(k, longint'($urandom_range(0, 6000)) - 3000);
      o  = int'($urandom_range(0, 15));
      sh = int'($urandom_range(0, 15));
      start(o, sh);
      cnt = ((o > 12) ? 12 : o) + int'($urandom_range(1, 6));
      for (int k = 0; k < cnt; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          r18 = 18'($urandom);
          d = longint'(r18);
        end else begin
          d = longint'($urandom_range(0, 1000)) - 500;
        end
        stl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        send(d, stl, 1'($urandom_range(0, 4) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
